// File: rtl/receptor_pacotes_if.sv
// Sensor link between the packet source and the receiver stage.
// Carries the incoming packet with its parity bit and the retransmission
// request travelling back towards the source.
interface receptor_pacotes_if;
    logic        pacote_valido;
    logic [10:0] pacote;
    logic        paridade;
    logic        solicitar_reenvio;
    logic [2:0]  id_reenvio;

    // Packet source: drives packets, listens for retransmission requests.
    modport master (
        output pacote_valido,
        output pacote,
        output paridade,
        input  solicitar_reenvio,
        input  id_reenvio
    );

    // Receiver: consumes packets, issues retransmission requests.
    modport slave (
        input  pacote_valido,
        input  pacote,
        input  paridade,
        output solicitar_reenvio,
        output id_reenvio
    );
endinterface

// File: rtl/receptor_pacotes.sv
// Receiver stage of the sensor link. Good packets land in E1..E8; a parity
// failure starts a retransmission request with timeout-driven re-requests and
// a bounded number of attempts. A frame is reported once all 8 sensors have
// been refreshed.
module receptor_pacotes #(
    parameter int TIMEOUT        = 16,
    parameter int MAX_TENTATIVAS = 3,
    parameter int CONT_W         = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    receptor_pacotes_if.slave    link,
    output logic [7:0]           E1,
    output logic [7:0]           E2,
    output logic [7:0]           E3,
    output logic [7:0]           E4,
    output logic [7:0]           E5,
    output logic [7:0]           E6,
    output logic [7:0]           E7,
    output logic [7:0]           E8,
    output logic [7:0]           atualizados,
    output logic                 quadro_completo,
    output logic                 erro_reenvio,
    output logic [2:0]           id_erro
);

    // Wide enough to hold the attempt count up to MAX_TENTATIVAS inclusive.
    localparam int TENT_W = $clog2(MAX_TENTATIVAS + 1);

    typedef enum logic {
        OCIOSO,
        ESPERA_REENVIO
    } estado_t;

    estado_t             estado_reg;
    logic [CONT_W-1:0]   cont_reg;
    logic [TENT_W-1:0]   tent_reg;
    logic                solicitar_reg;
    logic [2:0]          id_reenvio_reg;
    logic                quadro_reg;
    logic                erro_reg;
    logic [2:0]          id_erro_reg;
    logic [7:0]          atualizados_reg;
    logic [7:0]          atualizados_next;
    logic [7:0]          e_out [8];

    logic                pacote_ok;
    logic                pacote_ruim;
    logic [2:0]          id_pac;
    logic [7:0]          dado_pac;
    logic                casa_id;
    logic                expirou;

    // Even parity over packet plus parity bit; only valid cycles count.
    assign pacote_ok   = link.pacote_valido && !(^{link.pacote, link.paridade});
    assign pacote_ruim = link.pacote_valido &&  (^{link.pacote, link.paridade});
    assign id_pac      = link.pacote[10:8];
    assign dado_pac    = link.pacote[7:0];
    assign casa_id     = (id_pac == id_reenvio_reg);
    // Counter is cleared on the request edge, so TIMEOUT-1 here means TIMEOUT
    // edges have elapsed since the last request.
    assign expirou     = (cont_reg == CONT_W'(TIMEOUT - 1));

    // Refresh mask including this cycle's write, before frame wrap-around.
    always_comb begin
        atualizados_next = atualizados_reg;
        if (pacote_ok) begin
            atualizados_next = atualizados_reg | (8'h01 << id_pac);
        end
    end

    // One data register per sensor; every good packet is stored regardless of
    // whether a retransmission is outstanding.
    for (genvar gi = 0; gi < 8; gi++) begin : g_sensor
        logic [7:0] e_reg;

        // Capture the data byte of good packets addressed to this sensor.
        always_ff @(posedge clk) begin
            if (rst) begin
                e_reg <= 8'h00;
            end else if (pacote_ok && (id_pac == 3'(gi))) begin
                e_reg <= dado_pac;
            end
        end

        assign e_out[gi] = e_reg;
    end

    // Retransmission FSM plus frame tracking, all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_reg      <= OCIOSO;
            cont_reg        <= '0;
            tent_reg        <= '0;
            solicitar_reg   <= 1'b0;
            id_reenvio_reg  <= 3'd0;
            quadro_reg      <= 1'b0;
            erro_reg        <= 1'b0;
            id_erro_reg     <= 3'd0;
            atualizados_reg <= 8'h00;
        end else begin
            solicitar_reg <= 1'b0;
            erro_reg      <= 1'b0;

            // A completed frame restarts the mask from empty.
            if (atualizados_next == 8'hFF) begin
                quadro_reg      <= 1'b1;
                atualizados_reg <= 8'h00;
            end else begin
                quadro_reg      <= 1'b0;
                atualizados_reg <= atualizados_next;
            end

            case (estado_reg)
                OCIOSO: begin
                    if (pacote_ruim) begin
                        solicitar_reg  <= 1'b1;
                        id_reenvio_reg <= id_pac;
                        tent_reg       <= TENT_W'(1);
                        cont_reg       <= '0;
                        estado_reg     <= ESPERA_REENVIO;
                    end
                end
                ESPERA_REENVIO: begin
                    // The awaited packet wins over a simultaneous timeout.
                    if (pacote_ok && casa_id) begin
                        estado_reg <= OCIOSO;
                        cont_reg   <= '0;
                        tent_reg   <= '0;
                    end else if (expirou || (pacote_ruim && casa_id)) begin
                        if (tent_reg < TENT_W'(MAX_TENTATIVAS)) begin
                            solicitar_reg <= 1'b1;
                            tent_reg      <= tent_reg + 1'b1;
                            cont_reg      <= '0;
                        end else begin
                            erro_reg    <= 1'b1;
                            id_erro_reg <= id_reenvio_reg;
                            estado_reg  <= OCIOSO;
                            cont_reg    <= '0;
                            tent_reg    <= '0;
                        end
                    end else begin
                        // Bad packets for other IDs are dropped silently.
                        cont_reg <= cont_reg + 1'b1;
                    end
                end
                default: estado_reg <= OCIOSO;
            endcase
        end
    end

    assign link.solicitar_reenvio = solicitar_reg;
    assign link.id_reenvio        = id_reenvio_reg;
    assign E1                     = e_out[0];
    assign E2                     = e_out[1];
    assign E3                     = e_out[2];
    assign E4                     = e_out[3];
    assign E5                     = e_out[4];
    assign E6                     = e_out[5];
    assign E7                     = e_out[6];
    assign E8                     = e_out[7];
    assign atualizados            = atualizados_reg;
    assign quadro_completo        = quadro_reg;
    assign erro_reenvio           = erro_reg;
    assign id_erro                = id_erro_reg;

endmodule

// File: tb/tb_receptor_pacotes.sv
// Bench for receptor_pacotes: directed scenarios followed by random traffic.
// The stimulus side updates a cycle-level reference model and queues the
// expected outputs; a monitor pops one entry after every clock edge and
// compares it with the DUT.
module tb_receptor_pacotes;

    localparam int TIMEOUT = 16;
    localparam int MAX_TENT = 3;

    logic clk;
    logic rst;
    logic [7:0] E1, E2, E3, E4, E5, E6, E7, E8;
    logic [7:0] atualizados;
    logic       quadro_completo;
    logic       erro_reenvio;
    logic [2:0] id_erro;

    receptor_pacotes_if link ();

    receptor_pacotes #(
        .TIMEOUT        (TIMEOUT),
        .MAX_TENTATIVAS (MAX_TENT),
        .CONT_W         (5)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .link            (link.slave),
        .E1              (E1),
        .E2              (E2),
        .E3              (E3),
        .E4              (E4),
        .E5              (E5),
        .E6              (E6),
        .E7              (E7),
        .E8              (E8),
        .atualizados     (atualizados),
        .quadro_completo (quadro_completo),
        .erro_reenvio    (erro_reenvio),
        .id_erro         (id_erro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0][7:0] e;
        logic [7:0]      upd;
        logic            req;
        logic [2:0]      id_req;
        logic            quad;
        logic            err;
        logic [2:0]      id_err;
    } snap_t;

    snap_t sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    bit    started  = 1'b0;
    bit    done     = 1'b0;

    // Reference model: pending request tracked by absolute deadline cycle.
    logic [7:0] m_e [8];
    logic [7:0] m_upd;
    bit         m_pend;
    logic [2:0] m_pend_id;
    int         m_deadline;
    int         m_reqs;
    logic [2:0] m_id_erro;
    int         cyc = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
    endtask

    // Apply one clock edge worth of inputs to the model and queue the outcome.
    task automatic model_edge(input bit r, input bit v, input logic [10:0] pk, input logic par);
        snap_t s;
        bit    good;
        bit    req;
        bit    err;
        bit    quad;
        int    id;
        cyc++;
        req  = 0;
        err  = 0;
        quad = 0;
        id   = int'(pk[10:8]);
        if (r) begin
            for (int i = 0; i < 8; i++) m_e[i] = 8'h00;
            m_upd     = 8'h00;
            m_pend    = 0;
            m_pend_id = 3'd0;
            m_reqs    = 0;
            m_id_erro = 3'd0;
        end else begin
            good = v && ($countones({pk, par}) % 2 == 0);
            if (good) begin
                m_e[id]   = pk[7:0];
                m_upd[id] = 1'b1;
            end
            if (m_pend) begin
                if (good && pk[10:8] == m_pend_id) begin
                    m_pend = 0;
                end else if ((v && !good && pk[10:8] == m_pend_id) || cyc == m_deadline) begin
                    if (m_reqs < MAX_TENT) begin
                        req = 1;
                        m_reqs++;
                        m_deadline = cyc + TIMEOUT;
                    end else begin
                        err       = 1;
                        m_id_erro = m_pend_id;
                        m_pend    = 0;
                    end
                end
            end else if (v && !good) begin
                req        = 1;
                m_pend     = 1;
                m_pend_id  = pk[10:8];
                m_reqs     = 1;
                m_deadline = cyc + TIMEOUT;
            end
            if (m_upd == 8'hFF) begin
                quad  = 1;
                m_upd = 8'h00;
            end
        end
        for (int i = 0; i < 8; i++) s.e[i] = m_e[i];
        s.upd    = m_upd;
        s.req    = req;
        s.id_req = m_pend_id;
        s.quad   = quad;
        s.err    = err;
        s.id_err = m_id_erro;
        sb.push_back(s);
    endtask

    // Drive one cycle of inputs; bad=1 flips the parity bit.
    task automatic step(input bit r, input bit v, input int id, input int dado, input bit bad);
        logic [10:0] pk;
        logic        par;
        @(negedge clk);
        pk  = {id[2:0], dado[7:0]};
        par = (^pk) ^ bad;
        rst                = r;
        link.pacote_valido = v;
        link.pacote        = pk;
        link.paridade      = par;
        model_edge(r, v, pk, par);
        started = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    // Monitor: one expected snapshot per clock edge once stimulus has begun.
    initial begin
        snap_t x;
        wait (started);
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                if (!done) chk("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                x = sb.pop_front();
                chk("E1", {24'd0, E1}, {24'd0, x.e[0]});
                chk("E2", {24'd0, E2}, {24'd0, x.e[1]});
                chk("E3", {24'd0, E3}, {24'd0, x.e[2]});
                chk("E4", {24'd0, E4}, {24'd0, x.e[3]});
                chk("E5", {24'd0, E5}, {24'd0, x.e[4]});
                chk("E6", {24'd0, E6}, {24'd0, x.e[5]});
                chk("E7", {24'd0, E7}, {24'd0, x.e[6]});
                chk("E8", {24'd0, E8}, {24'd0, x.e[7]});
                chk("atualizados", {24'd0, atualizados}, {24'd0, x.upd});
                chk("solicitar_reenvio", {31'd0, link.solicitar_reenvio}, {31'd0, x.req});
                chk("id_reenvio", {29'd0, link.id_reenvio}, {29'd0, x.id_req});
                chk("quadro_completo", {31'd0, quadro_completo}, {31'd0, x.quad});
                chk("erro_reenvio", {31'd0, erro_reenvio}, {31'd0, x.err});
                chk("id_erro", {29'd0, id_erro}, {29'd0, x.id_err});
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        bit quiet;
        int id;
        rst                = 1'b1;
        link.pacote_valido = 1'b0;
        link.pacote        = 11'd0;
        link.paridade      = 1'b0;

        // Reset, then one full frame of single-bit data.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, i, 1 << i, 0);
        idle(2);

        // Bad packet answered by a good one five cycles later.
        step(0, 1, 2, 8'h04, 1);
        idle(4);
        step(0, 1, 2, 8'h04, 0);
        idle(3);

        // Unanswered request: two re-requests, then error.
        step(0, 1, 5, 8'h55, 1);
        idle(52);

        // Unrelated traffic during a wait, then the awaited packet.
        step(0, 1, 1, 8'h11, 1);
        step(0, 1, 4, 8'h10, 0);
        step(0, 1, 6, 8'h66, 1);
        idle(3);
        step(0, 1, 1, 8'h12, 0);
        idle(2);

        // Awaited packet lands exactly on the timeout edge.
        step(0, 1, 3, 8'h33, 1);
        idle(TIMEOUT - 1);
        step(0, 1, 3, 8'h34, 0);
        idle(3);

        // Reset in the middle of a wait with six sensors refreshed.
        for (int i = 0; i < 6; i++) step(0, 1, i, 8'hA0 + i, 0);
        step(0, 1, 6, 8'h77, 1);
        idle(4);
        step(1, 0, 0, 0, 0);
        step(0, 1, 7, 8'h5A, 0);
        idle(2);

        // Random traffic in blocks of busy and quiet periods.
        for (int b = 0; b < 40; b++) begin
            quiet = ($urandom_range(0, 3) == 0);
            for (int c = 0; c < 40; c++) begin
                id = int'($urandom_range(0, 7));
                if (m_pend && $urandom_range(0, 2) == 0) id = int'(m_pend_id);
                step($urandom_range(0, 399) == 0,
                     quiet ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0),
                     id, int'($urandom_range(0, 255)),
                     $urandom_range(0, 4) == 0);
            end
        end
        idle(2);
        done = 1'b1;

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
